// File: rtl/dcsa_pkg.sv
// Shared definitions for the duplicated carry-select adder and its result checker.
package dcsa_pkg;

  localparam int W_DEF = 64;
  localparam int G_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALARM    = 2'd1,
    WAIT_REL = 2'd2
  } alarm_state_t;

  function automatic logic parity_fold(input logic [W_DEF-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dcsa_group_cmp.sv
// One compare group: flags any bit where the duplicate is not the complement of the sum.
module dcsa_group_cmp #(
  parameter int G = 8
) (
  input  logic [G-1:0] s_g,
  input  logic [G-1:0] s_inv_g,
  output logic         mis
);

  assign mis = ~&(s_g ^ s_inv_g);

endmodule

// File: rtl/dcsa_result_checker_64b.sv
// Two-stage checker for the duplicated adder outputs, with error logging and an
// alarm/ack handshake towards the fault manager.
module dcsa_result_checker_64b
  import dcsa_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int G     = G_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     s_invert,
  input  logic             papb,
  input  logic             pab,
  output logic             chk_valid,
  output logic             chk_dup_err,
  output logic             chk_par_err,
  output logic [W/G-1:0]   chk_grp,
  output logic             alarm,
  input  logic             alarm_ack,
  output logic [W/G-1:0]   first_grp,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear
);

  localparam int NG = W / G;

  logic [NG-1:0] grp_mis;
  logic [NG-1:0] grp_q;
  logic          par_q;
  logic          v1;
  logic          err;
  logic          first_grp_set;
  logic          pend;
  logic          pend_eff;

  alarm_state_t state, state_nxt;

  for (genvar g = 0; g < NG; g++) begin : g_cmp
    dcsa_group_cmp #(.G(G)) u_cmp (
      .s_g     (s[g*G +: G]),
      .s_inv_g (s_invert[g*G +: G]),
      .mis     (grp_mis[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      grp_q <= '0;
      par_q <= 1'b0;
    end else begin
      v1    <= in_valid;
      grp_q <= grp_mis;
      par_q <= papb ^ pab;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid   <= 1'b0;
      chk_grp     <= '0;
      chk_dup_err <= 1'b0;
      chk_par_err <= 1'b0;
    end else begin
      chk_valid   <= v1;
      chk_grp     <= v1 ? grp_q : '0;
      chk_dup_err <= v1 & (|grp_q);
      chk_par_err <= v1 & par_q;
    end
  end

  assign err = chk_valid & (chk_dup_err | chk_par_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= {{(CNT_W-1){1'b0}}, err};
    end else if (err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_grp     <= '0;
      first_grp_set <= 1'b0;
    end else if (clear) begin
      first_grp     <= err ? chk_grp : '0;
      first_grp_set <= err;
    end else if (err && !first_grp_set) begin
      first_grp     <= chk_grp;
      first_grp_set <= 1'b1;
    end
  end

  // Errors seen while the ack is still held are remembered; a same-cycle clear
  // already masks the old bit for the release decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if ((state == WAIT_REL) && alarm_ack && err) begin
      pend <= 1'b1;
    end else if (clear || (state != WAIT_REL) || !alarm_ack) begin
      pend <= 1'b0;
    end
  end

  assign pend_eff = pend & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (err) state_nxt = ALARM;
      ALARM:    if (alarm_ack) state_nxt = WAIT_REL;
      WAIT_REL: if (!alarm_ack) state_nxt = (err || pend_eff) ? ALARM : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alarm = 1'b0;
    if (state == ALARM) alarm = 1'b1;
  end

endmodule

// File: doc/dcsa_result_checker_64b.md
Name: dcsa_result_checker_64b

Overview:
- Receiving end of the 64-bit duplicated carry-select adder's self-checking outputs.
- Consumes the sum pair (s, s_invert) and the two parity terms (papb, pab). Flags a duplication mismatch when s_invert is not the bitwise complement of s. Flags a parity fault when papb differs from pab.
- Two-stage pipelined; sits directly after the adder and feeds the fault-management logic through an alarm/ack handshake.

Parameters:
- W, 64, datapath width; must be a multiple of G.
- G, 8, bits per compare group; NG = W/G groups (8 by default).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  s, s_invert, papb and pab are valid this cycle.
- s  in  W  primary sum.
- s_invert  in  W  complemented duplicate sum.
- papb  in  1  pa^pb from the adder.
- pab  in  1  parity of a^b from the adder.
- chk_valid  out  1  check result valid; 2 cycles after in_valid.
- chk_dup_err  out  1  duplication mismatch in this result.
- chk_par_err  out  1  parity mismatch in this result.
- chk_grp  out  NG  per-group mismatch bitmap; bit g covers bits [g*G+G-1 : g*G].
- alarm  out  1  level request to fault manager.
- alarm_ack  in  1  fault manager acknowledge.
- first_grp  out  NG  chk_grp of the first error since the last clear.
- err_count  out  CNT_W  number of erroneous results, saturating.
- clear  in  1  synchronous clear of first_grp and err_count.

Behaviour:
- Reset (async, rst=1): every output is 0; FSM is in IDLE; pipeline valids are 0.
- Stage 1 (registered at edge after in_valid):
  - grp_mis[g] = ~&(s[g] ^ s_invert[g]) for each group g.
  - par_mis = papb ^ pab.
  - v1 = in_valid.
- Stage 2 (registered):
  - chk_valid = v1; chk_grp = grp_mis; chk_dup_err = |grp_mis; chk_par_err = par_mis.
  - When v1 = 0, the stage-2 error outputs are forced to 0.
- Latency is exactly 2 cycles. Throughput is one result per cycle with no backpressure; in_valid gaps propagate unchanged.
- A result is erroneous when chk_valid & (chk_dup_err | chk_par_err).
- err_count:
  - Increments by 1 on each erroneous result and saturates at 2^CNT_W-1.
  - clear sets it to 0. If clear and an erroneous result coincide, the result is 1.
- first_grp:
  - Captures chk_grp on the first erroneous result while first_grp_set = 0.
  - A parity-only error (chk_grp = 0) still sets first_grp_set, capturing 0.
  - clear resets first_grp and first_grp_set. If clear and an erroneous result coincide, the new result is captured.
- Alarm FSM, states IDLE, ALARM, WAIT_REL:
  - IDLE: on an erroneous result -> ALARM next cycle; alarm = 1 from that cycle.
  - ALARM: alarm = 1. On alarm_ack = 1 -> WAIT_REL with alarm = 0. Further errors in ALARM only update the counter.
  - WAIT_REL: alarm = 0; waits for alarm_ack = 0.
    - alarm_ack = 0 and an erroneous result in the same cycle -> ALARM.
    - alarm_ack = 0 and no error -> IDLE.
  - Errors that arrive while in WAIT_REL with alarm_ack still 1 are counted. They set a pending bit, and the pending bit forces WAIT_REL -> ALARM on release.
  - alarm_ack in IDLE is ignored.
  - clear does not change FSM state. It does drop the pending bit.
- Reset mid-operation: pipeline contents are discarded; no chk_valid is produced for inputs accepted before reset.

Decomposition:
- Shared package dcsa_pkg holds:
  - constants W_DEF = 64, G_DEF = 8;
  - the alarm state enum alarm_state_t {IDLE, ALARM, WAIT_REL};
  - function parity_fold(vector) used by adder-side and checker-side benches.
- One natural sub-module: dcsa_group_cmp (parameter G). Inputs s_g and s_inv_g; output mis = ~&(s_g ^ s_inv_g). Instantiated NG times in a generate loop.

Test Plan:
- Clean stream: in_valid = 1 for 10 cycles with s = 64'h0123_4567_89AB_CDEF, s_invert = ~s, papb = pab = 1. Required: chk_valid high cycles 2..11, every error output 0, err_count = 0, alarm never set.
- Duplication fault: s_invert bit 20 flipped (s_invert = ~s ^ 64'h0010_0000). Required, 2 cycles later: chk_dup_err = 1, chk_grp = 8'h04, first_grp = 8'h04, err_count = 1; alarm rises one cycle after chk_valid.
- Parity fault only: papb = 1, pab = 0, s_invert = ~s. Required: chk_par_err = 1, chk_grp = 0, err_count = 1, alarm = 1; with alarm_ack pulsed 1 then 0, FSM goes ALARM -> WAIT_REL -> IDLE and alarm = 0.
- Pending during ack:
  - Stimulus: hold alarm_ack = 1 in WAIT_REL while 3 erroneous results arrive, then drop ack.
  - Required: err_count increments by 3, alarm stays 0 during ack, and alarm reasserts the cycle after ack falls.
- Saturation/clear:
  - Stimulus: CNT_W = 4, 20 consecutive errors, then clear coincident with an error.
  - Required: err_count stops at 15, then reads 1 after clear; first_grp is recaptured.
- Async reset mid-stream: assert rst between clock edges with 2 results in flight. Required: all outputs 0 immediately; no chk_valid after rst is released until new in_valid + 2 cycles.
